// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory between the row and column 1-D IDCT passes.
// Rows are written into one bank while columns of the other bank are read out.
module idct_transpose_buffer #(
   parameter int DW = 9,
   parameter int N  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_row,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*DW-1:0] out_col,
   output logic            out_last
);

   localparam int PW = $clog2(N);
   localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

   logic [DW-1:0] bank_mem [2][N][N];

   logic [1:0]    full_reg;
   logic [1:0]    full_next;
   logic          wb_reg;
   logic          wb_next;
   logic          rb_reg;
   logic          rb_next;
   logic [PW-1:0] wrow_reg;
   logic [PW-1:0] wrow_next;
   logic [PW-1:0] rcol_reg;
   logic [PW-1:0] rcol_next;

   logic wr_fire;
   logic rd_fire;
   logic wr_done;
   logic rd_done;

   // Handshake status comes only from registered bank state, never from in_valid.
   assign in_ready  = ~full_reg[wb_reg];
   assign out_valid = full_reg[rb_reg];
   assign out_last  = out_valid && (rcol_reg == LAST_IDX);

   assign wr_fire = in_valid && in_ready;
   assign rd_fire = out_valid && out_ready;
   assign wr_done = wr_fire && (wrow_reg == LAST_IDX);
   assign rd_done = rd_fire && (rcol_reg == LAST_IDX);

   always_comb begin
      full_next = full_reg;
      wb_next   = wb_reg;
      rb_next   = rb_reg;
      wrow_next = wrow_reg;
      rcol_next = rcol_reg;

      if (wr_fire) begin
         wrow_next = wrow_reg + PW'(1);
      end
      if (wr_done) begin
         wrow_next         = '0;
         full_next[wb_reg] = 1'b1;
         wb_next           = ~wb_reg;
      end

      if (rd_fire) begin
         rcol_next = rcol_reg + PW'(1);
      end
      // A completing write and a completing read always target different banks.
      if (rd_done) begin
         rcol_next         = '0;
         full_next[rb_reg] = 1'b0;
         rb_next           = ~rb_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_reg <= 2'b00;
         wb_reg   <= 1'b0;
         rb_reg   <= 1'b0;
         wrow_reg <= '0;
         rcol_reg <= '0;
      end else begin
         full_reg <= full_next;
         wb_reg   <= wb_next;
         rb_reg   <= rb_next;
         wrow_reg <= wrow_next;
         rcol_reg <= rcol_next;
      end
   end

   // Storage is deliberately left out of reset; the bank flags gate its use.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int j = 0; j < N; j++) begin
            bank_mem[wb_reg][wrow_reg][j] <= in_row[(N-1-j)*DW +: DW];
         end
      end
   end

   // Element 0 sits in the most significant slice, same as the row packing.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_col
         assign out_col[(N-1-gi)*DW +: DW] =
            out_valid ? bank_mem[rb_reg][gi][rcol_reg] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Self-checking bench for idct_transpose_buffer against a queue-based block model.
`timescale 1ns/1ps
module tb_idct_transpose_buffer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [71:0] in_row;
   logic        out_valid;
   logic        out_ready;
   logic [71:0] out_col;
   logic        out_last;

   int tests_run;
   int tests_failed;

   // Model: rows of the block being assembled, and columns awaiting output.
   logic [71:0] part_q[$];
   logic [72:0] cols_q[$];
   logic [71:0] tx_q[$];

   idct_transpose_buffer #(.DW(9), .N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {in_ready, out_valid, out_last, out_col}.
   function automatic logic [74:0] exp_vec();
      int blocks;
      logic [74:0] v;
      blocks = (cols_q.size() + 7) / 8;
      v = '0;
      v[74] = (blocks < 2);
      if (cols_q.size() > 0) begin
         v[73] = 1'b1;
         v[72] = cols_q[0][72];
         v[71:0] = cols_q[0][71:0];
      end
      return v;
   endfunction

   function automatic logic [71:0] make_row(input int base);
      logic [71:0] r;
      for (int j = 0; j < 8; j++) r[(7-j)*9 +: 9] = 9'((base + j) % 512);
      return r;
   endfunction

   task automatic step(input logic v, input logic [71:0] row, input logic ordy,
                       input logic r, output logic acc);
      logic [74:0] e;
      logic cons;
      logic [71:0] col;
      e = exp_vec();
      acc  = v && e[74] && !r;
      cons = e[73] && ordy && !r;
      in_valid  = v;
      in_row    = row;
      out_ready = ordy;
      rst       = r;
      @(posedge clk);
      if (r) begin
         part_q.delete();
         cols_q.delete();
      end else begin
         if (cons) void'(cols_q.pop_front());
         if (acc) begin
            part_q.push_back(row);
            if (part_q.size() == 8) begin
               for (int c = 0; c < 8; c++) begin
                  for (int k = 0; k < 8; k++) col[(7-k)*9 +: 9] = part_q[k][(7-c)*9 +: 9];
                  cols_q.push_back({(c == 7), col});
               end
               part_q.delete();
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic acc;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 1'b1, acc);
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== {1'b1, 1'b0, 1'b0, 72'd0}) begin
            tests_failed++;
            $display("FAIL reset cyc=%0d got ir=%b ov=%b last=%b col=%h want ir=1 ov=0 last=0 col=0",
                     i, in_ready, out_valid, out_last, out_col);
         end
      end
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single_block();
      logic acc;
      logic [74:0] e;
      logic [71:0] col3;
      int cyc, ncol;
      col3 = {9'd3, 9'd11, 9'd19, 9'd27, 9'd35, 9'd43, 9'd51, 9'd59};
      for (int r = 0; r < 8; r++) tx_q.push_back(make_row(r * 8));
      cyc = 0; ncol = 0;
      while ((tx_q.size() > 0 || cols_q.size() > 0) && cyc < 100) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL single_block cyc=%0d got %h want %h", cyc,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         if (out_valid && ncol == 3) begin
            tests_run++;
            if (out_col !== col3) begin
               tests_failed++;
               $display("FAIL single_col3 got %h want %h", out_col, col3);
            end
         end
         if (out_valid) ncol++;
         step(tx_q.size() > 0, (tx_q.size() > 0) ? tx_q[0] : 72'd0, 1'b1, 1'b0, acc);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      tests_run++;
      if (ncol != 8 || cyc >= 100) begin
         tests_failed++;
         $display("FAIL single_count got %0d columns want 8 (cycles %0d)", ncol, cyc);
      end
   endtask

   task automatic test_streaming();
      logic acc;
      logic [74:0] e;
      int cyc, ncol;
      for (int b = 0; b < 4; b++)
         for (int r = 0; r < 8; r++) tx_q.push_back(make_row(b * 64 + r * 8));
      cyc = 0; ncol = 0;
      while ((tx_q.size() > 0 || cols_q.size() > 0) && cyc < 200) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL streaming cyc=%0d got %h want %h", cyc,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         if (tx_q.size() > 0) begin
            tests_run++;
            if (in_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL streaming_ready cyc=%0d got %b want 1", cyc, in_ready);
            end
         end
         if (out_valid) ncol++;
         step(tx_q.size() > 0, (tx_q.size() > 0) ? tx_q[0] : 72'd0, 1'b1, 1'b0, acc);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      tests_run++;
      if (ncol != 32 || cyc != 40) begin
         tests_failed++;
         $display("FAIL streaming_rate got %0d columns in %0d cycles want 32 in 40", ncol, cyc);
      end
   endtask

   task automatic test_backpressure();
      logic acc;
      logic [74:0] e;
      int cyc, nacc;
      for (int i = 0; i < 24; i++) tx_q.push_back({$urandom, $urandom, $urandom});
      nacc = 0;
      for (int i = 0; i < 30; i++) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL backpressure_hold cyc=%0d got %h want %h", i,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         step(1'b1, tx_q[0], 1'b0, 1'b0, acc);
         if (acc) begin
            void'(tx_q.pop_front());
            nacc++;
         end
      end
      tests_run++;
      if (nacc != 16 || in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL backpressure_stall got %0d rows ir=%b want 16 rows ir=0", nacc, in_ready);
      end
      cyc = 0;
      while ((tx_q.size() > 0 || cols_q.size() > 0) && cyc < 200) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL backpressure_drain cyc=%0d got %h want %h", cyc,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         step(tx_q.size() > 0, (tx_q.size() > 0) ? tx_q[0] : 72'd0, 1'b1, 1'b0, acc);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      tests_run++;
      if (cyc >= 200) begin
         tests_failed++;
         $display("FAIL backpressure_timeout got %0d cycles want < 200", cyc);
      end
   endtask

   task automatic test_extremes();
      logic acc;
      logic [74:0] e;
      logic [71:0] r;
      int cyc;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 8; j++) r[(7-j)*9 +: 9] = ($urandom_range(0, 1) == 1) ? 9'h100 : 9'h0FF;
         tx_q.push_back(r);
      end
      cyc = 0;
      while ((tx_q.size() > 0 || cols_q.size() > 0) && cyc < 300) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL extremes cyc=%0d got %h want %h", cyc,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         step(tx_q.size() > 0 && $urandom_range(0, 3) != 0,
              (tx_q.size() > 0) ? tx_q[0] : 72'd0, 1'($urandom_range(0, 1)), 1'b0, acc);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      tests_run++;
      if (cyc >= 300) begin
         tests_failed++;
         $display("FAIL extremes_timeout got %0d cycles want < 300", cyc);
      end
   endtask

   task automatic test_reset_mid_block();
      logic acc;
      logic [74:0] e;
      int cyc, ncol;
      for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom, $urandom}, 1'b1, 1'b0, acc);
      step(1'b0, 72'd0, 1'b1, 1'b1, acc);
      tests_run++;
      if ({in_ready, out_valid, out_col} !== {1'b1, 1'b0, 72'd0}) begin
         tests_failed++;
         $display("FAIL midreset_state got ir=%b ov=%b col=%h want ir=1 ov=0 col=0",
                  in_ready, out_valid, out_col);
      end
      for (int r = 0; r < 8; r++) tx_q.push_back(make_row(200 + r * 8));
      cyc = 0; ncol = 0;
      while ((tx_q.size() > 0 || cols_q.size() > 0) && cyc < 100) begin
         e = exp_vec();
         tests_run++;
         if ({in_ready, out_valid, out_last, out_col} !== e) begin
            tests_failed++;
            $display("FAIL midreset_block cyc=%0d got %h want %h", cyc,
                     {in_ready, out_valid, out_last, out_col}, e);
         end
         if (out_valid) ncol++;
         step(tx_q.size() > 0, (tx_q.size() > 0) ? tx_q[0] : 72'd0, 1'b1, 1'b0, acc);
         if (acc) void'(tx_q.pop_front());
         cyc++;
      end
      tests_run++;
      if (ncol != 8 || cyc >= 100) begin
         tests_failed++;
         $display("FAIL midreset_count got %0d columns want 8", ncol);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_row = '0;
      out_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_block();
      test_streaming();
      test_backpressure();
      test_extremes();
      test_reset_mid_block();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/idct_transpose_buffer.md
# idct_transpose_buffer

Ping-pong 8x8 transpose memory between the row (first-pass) 1-D IDCT and the column (second-pass) 1-D IDCT in the JPEG decode path. It accepts one 72-bit row of eight 9-bit row-IDCT results per handshake and stores a full 8x8 block. It then emits the block column by column in the same 72-bit packing. Two banks let block n+1 be written while block n is read, which sustains one row in and one column out per cycle.

## Interface
Parameters:
- DW, 9: bits per element.
- N, 8: block dimension. Fixed at 8; other values are not supported.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  in_row carries a valid row.
- in_ready  out  1  buffer can accept a row this cycle.
- in_row  in  72  eight DW-bit elements. Element 0 is at [71:63] and element 7 at [8:0]; this matches the row IDCT output packing.
- out_valid  out  1  out_col carries a valid column.
- out_ready  in  1  the column IDCT consumes out_col this cycle.
- out_col  out  72  column c of the block. Element k is row k of column c; element 0 is at [71:63].
- out_last  out  1  high together with out_valid when column 7 is presented.

## Operation
- Storage: bank[2][8 rows][8 cols] of DW bits.
- Per-bank state, one bit each: EMPTY or FULL.
- Pointers:
  - wb: write bank.
  - rb: read bank.
  - wrow: 3-bit row counter.
  - rcol: 3-bit column counter.
- Write side:
  - in_ready = (bank wb is EMPTY).
  - When in_valid && in_ready, in_row element j is stored to bank[wb][wrow][j] for j=0..7, and wrow increments.
  - When the accepted row has wrow==7: wrow wraps to 0, bank wb becomes FULL, and wb toggles.
  - A row offered while in_ready=0 is not stored. The upstream stage holds in_row and in_valid stable until the row is accepted.
- Read side:
  - out_valid = (bank rb is FULL).
  - out_col element k = bank[rb][k][rcol].
  - out_last = out_valid && rcol==7.
  - When out_valid && out_ready, rcol increments.
  - When the consumed column has rcol==7: rcol wraps to 0, bank rb becomes EMPTY, and rb toggles.
- When out_valid=0, out_col is driven to 0.
- Simultaneous events:
  - Completing a write to one bank and releasing the other bank in the same cycle both take effect.
  - A bank's FULL set and EMPTY clear never target the same bank in the same cycle.
  - When both banks are FULL, in_ready=0 until a read completes. When both banks are EMPTY, out_valid=0.
- Element values pass through unmodified. There is no arithmetic, sign extension or rounding.
- Reset:
  - wb=rb=0 and wrow=rcol=0.
  - Both banks are EMPTY.
  - Any partially written or partially read block is discarded.
  - Storage contents are not cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, out_col=0. These hold in the cycle after rst is sampled high.
- Latency: if the 8th row of a block is accepted at edge E, out_valid is high and column 0 is presented immediately after E.
- Reads are combinational from registered state. out_col and out_valid change only after clock edges.
- Throughput: with in_valid and out_ready held at 1, one row is accepted every cycle and, after the first block, one column is emitted every cycle, with no bubbles.
- While out_valid=1 and out_ready=0, out_col, out_valid and out_last stay stable.
- in_ready depends only on registered state and never on in_valid, so there is no combinational path from in_valid to in_ready.

## Test plan
- Reset behaviour: assert rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0 and out_col=0; no row is stored.
- Single block:
  - Stimulus: write rows r=0..7 with element j = r*8+j, for example row 2 = {16,17,...,23}.
  - Required: out_valid rises right after row 7 is accepted.
  - Required: columns come out as column c = {c, 8+c, ..., 56+c}; column 3 = {3,11,19,27,35,43,51,59}.
  - Required: out_last is high only on column 7.
- Full-rate streaming: 4 back-to-back blocks with element values offset by 64 per block, with in_valid=out_ready=1 throughout -> in_ready never drops and all 32 columns are correct and in order.
- Backpressure:
  - Stimulus: hold out_ready=0 and write 3 blocks.
  - Required: in_ready drops to 0 after 16 rows are accepted and rows 17 onward stall.
  - Stimulus: raise out_ready.
  - Required: block 0 drains, then in_ready returns to 1 in the cycle after column 7 of block 0 is consumed.
- Signed extremes: elements 9'h100 (-256) and 9'h0FF (+255) -> the same bit patterns appear transposed at the output.
- Reset mid-block: accept 5 rows, assert rst, then write a full new block -> only the new block is output, and out_valid stays 0 until its 8th row is accepted.
